// File: rtl/ram_pkg.sv
// Shared constants, clear-FSM state encoding and byte-merge helper for the
// multimode single-port RAM.
package ram_pkg;

    localparam int WM_NO_CHANGE   = 0;
    localparam int WM_READ_FIRST  = 1;
    localparam int WM_WRITE_FIRST = 2;

    // Upper bound on word width accepted by byte_merge; callers zero-extend.
    localparam int MERGE_W = 1024;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_w,
        input logic [MERGE_W-1:0] new_w,
        input logic [MERGE_W-1:0] mask
    );
        return (old_w & ~mask) | (new_w & mask);
    endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset memory clear sequencer: sweeps every address once, writing zero,
// and holds busy high until the last word has been cleared.
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

    clr_state_t            state, state_nxt;
    logic [ADDR_WIDTH:0]   cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_we    = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy = 1'b1;
                // No array writes while reset is still asserted.
                clr_we  = rst_n;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_ADDR)
                    state_nxt = ST_IDLE;
            end
            default: ;
        endcase
    end

    assign clr_addr = cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/single_port_ram_multimode.sv
// Single-port synchronous RAM with selectable write-collision mode, byte-lane
// writes, optional output register and reset-triggered clear sweep.
module single_port_ram_multimode
    import ram_pkg::*;
#(
    parameter int MEM_WIDTH      = 24,
    parameter int ADDR_WIDTH     = 8,
    parameter int BYTE_WIDTH     = 8,
    parameter int WRITE_MODE     = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NUM_BYTES     = MEM_WIDTH / BYTE_WIDTH,
    localparam int MEM_DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [NUM_BYTES-1:0]  be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [MEM_WIDTH-1:0]  din,
    output logic [MEM_WIDTH-1:0]  dout,
    output logic                  dout_valid,
    output logic                  busy
);

    if (WRITE_MODE < WM_NO_CHANGE || WRITE_MODE > WM_WRITE_FIRST) begin : g_bad_mode
        $error("single_port_ram_multimode: WRITE_MODE must be 0, 1 or 2");
    end
    if (MEM_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("single_port_ram_multimode: MEM_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  acc;
    logic [MEM_WIDTH-1:0]  old_word;
    logic [MEM_WIDTH-1:0]  merged;
    logic [MEM_WIDTH-1:0]  wmask;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [MEM_WIDTH-1:0]  wr_data;
    logic [MEM_WIDTH-1:0]  dout_p1;
    logic                  vld_p1;

    ram_clear_ctrl #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_mask
        assign wmask[g*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{be[g]}};
    end

    assign acc      = en && !busy && rst_n;
    assign old_word = mem[addr];
    assign merged   = MEM_WIDTH'(byte_merge(MERGE_W'(old_word), MERGE_W'(din), MERGE_W'(wmask)));

    // The clear sweep owns the port while busy; user accesses are dropped.
    assign wr_en   = clr_we || (acc && we);
    assign wr_addr = clr_we ? clr_addr : addr;
    assign wr_data = clr_we ? '0 : merged;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // ---- stage 1: array read / collision result ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= acc && (!we || WRITE_MODE != WM_NO_CHANGE);
            if (acc) begin
                if (!we || WRITE_MODE == WM_READ_FIRST)
                    dout_p1 <= old_word;
                else if (WRITE_MODE == WM_WRITE_FIRST)
                    dout_p1 <= merged;
            end
        end
    end

    // ---- stage 2: optional output register ----
    if (OUT_REG != 0) begin : g_out_reg
        logic [MEM_WIDTH-1:0] dout_p2;
        logic                 vld_p2;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dout_p2 <= '0;
                vld_p2  <= 1'b0;
            end else begin
                vld_p2 <= vld_p1;
                if (vld_p1)
                    dout_p2 <= dout_p1;
            end
        end

        assign dout       = dout_p2;
        assign dout_valid = vld_p2;
    end else begin : g_no_out_reg
        assign dout       = dout_p1;
        assign dout_valid = vld_p1;
    end

endmodule

// File: tb/tb_single_port_ram_multimode.sv
// Directed bench: four RAM instances (three write modes, one registered
// output) share one stimulus stream; expected values are hand-computed.
module tb_single_port_ram_multimode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        we;
    logic [2:0]  be;
    logic [7:0]  addr;
    logic [23:0] din;

    logic [23:0] dout_m0, dout_m1, dout_m2, dout_or;
    logic        vld_m0, vld_m1, vld_m2, vld_or;
    logic        busy_m0, busy_m1, busy_m2, busy_or;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    single_port_ram_multimode #(.WRITE_MODE(0), .OUT_REG(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr),
        .din(din), .dout(dout_m0), .dout_valid(vld_m0), .busy(busy_m0));
    single_port_ram_multimode #(.WRITE_MODE(1), .OUT_REG(0)) u_m1 (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr),
        .din(din), .dout(dout_m1), .dout_valid(vld_m1), .busy(busy_m1));
    single_port_ram_multimode #(.WRITE_MODE(2), .OUT_REG(0)) u_m2 (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr),
        .din(din), .dout(dout_m2), .dout_valid(vld_m2), .busy(busy_m2));
    single_port_ram_multimode #(.WRITE_MODE(0), .OUT_REG(1)) u_or (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr),
        .din(din), .dout(dout_or), .dout_valid(vld_or), .busy(busy_or));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic w, input logic [7:0] a, input logic [23:0] d, input logic [2:0] b);
        en = 1'b1; we = w; addr = a; din = d; be = b;
        step();
        en = 1'b0; we = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_m0 && n < 400) begin
            n++;
            step();
        end
    endtask

    int          n;
    logic [23:0] exp_d [6];
    logic        exp_v [6];

    initial begin
        rst_n = 1'b0; en = 1'b0; we = 1'b0; be = 3'b000; addr = '0; din = '0;

        // Test 1: reset and clear sweep
        step(); step();
        chk("rst_dout",    32'(dout_m0), 32'h0);
        chk("rst_valid",   32'(vld_m0),  32'h0);
        chk("rst_busy",    32'(busy_m0), 32'h1);
        chk("rst_or_dout", 32'(dout_or), 32'h0);
        chk("rst_or_vld",  32'(vld_or),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        count_busy(n);
        chk("busy_cycles", 32'(n), 32'd256);
        chk("busy_or_low", 32'(busy_or), 32'h0);
        acc(1'b0, 8'h55, 24'h0, 3'b000);
        chk("clr_rd_dout", 32'(dout_m0), 32'h0);
        chk("clr_rd_vld",  32'(vld_m0),  32'h1);

        // Test 2: byte enables (plus read-first return of the old word)
        acc(1'b1, 8'h10, 24'hA1B2C3, 3'b111);
        acc(1'b1, 8'h10, 24'hFFFFFF, 3'b010);
        chk("rf_old_word", 32'(dout_m1), 32'hA1B2C3);
        acc(1'b0, 8'h10, 24'h0, 3'b000);
        chk("be_merge",    32'(dout_m0), 32'hA1FFC3);

        // Test 3: collision modes
        acc(1'b1, 8'h20, 24'h123456, 3'b111);
        acc(1'b1, 8'h21, 24'h0000AA, 3'b111);
        acc(1'b0, 8'h21, 24'h0, 3'b000);
        chk("pre_dout", 32'(dout_m0), 32'h0000AA);
        acc(1'b1, 8'h20, 24'hABCDEF, 3'b011);
        chk("nc_dout", 32'(dout_m0), 32'h0000AA);
        chk("nc_vld",  32'(vld_m0),  32'h0);
        chk("rf_dout", 32'(dout_m1), 32'h123456);
        chk("rf_vld",  32'(vld_m1),  32'h1);
        chk("wf_dout", 32'(dout_m2), 32'h12CDEF);
        chk("wf_vld",  32'(vld_m2),  32'h1);
        acc(1'b0, 8'h20, 24'h0, 3'b000);
        chk("raw_20", 32'(dout_m0), 32'h12CDEF);
        // we=1 with be=0: no update, mode rule still applies
        acc(1'b1, 8'h20, 24'hFFFFFF, 3'b000);
        chk("be0_wf_dout", 32'(dout_m2), 32'h12CDEF);
        chk("be0_nc_vld",  32'(vld_m0),  32'h0);
        acc(1'b0, 8'h20, 24'h0, 3'b000);
        chk("be0_unchanged", 32'(dout_m0), 32'h12CDEF);

        // Test 4: registered output, back-to-back reads
        acc(1'b1, 8'h11, 24'h111111, 3'b111);
        acc(1'b1, 8'h12, 24'h121212, 3'b111);
        step(); step();
        exp_v = '{0, 1, 1, 1, 0, 0};
        exp_d = '{24'h0, 24'hA1FFC3, 24'h111111, 24'h121212, 24'h121212, 24'h121212};
        for (int k = 0; k < 6; k++) begin
            en = (k < 3); we = 1'b0; addr = 8'h10 + 8'(k);
            step();
            chk($sformatf("or_vld_%0d", k), 32'(vld_or), 32'(exp_v[k]));
            if (k > 0)
                chk($sformatf("or_dout_%0d", k), 32'(dout_or), 32'(exp_d[k]));
        end
        en = 1'b0;

        // Test 6: idle hold
        en = 1'b0; we = 1'b1; din = 24'h777777; addr = 8'h30; be = 3'b111;
        step();
        we = 1'b0;
        chk("idle_vld",  32'(vld_m0),  32'h0);
        chk("idle_dout", 32'(dout_m0), 32'h121212);
        acc(1'b0, 8'h30, 24'h0, 3'b000);
        chk("idle_mem", 32'(dout_m0), 32'h0);

        // Test 5: reset in the middle of a sweep
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        repeat (100) step();
        chk("mid_busy", 32'(busy_m0), 32'h1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_dout", 32'(dout_m0), 32'h0);
        chk("mid_rst_vld",  32'(vld_m0),  32'h0);
        rst_n = 1'b1;
        en = 1'b1; we = 1'b1; addr = 8'h05; din = 24'h111111; be = 3'b111;
        count_busy(n);
        en = 1'b0; we = 1'b0;
        chk("mid_busy_cycles", 32'(n), 32'd256);
        acc(1'b0, 8'h05, 24'h0, 3'b000);
        chk("busy_wr_dropped", 32'(dout_m0), 32'h0);
        chk("busy_wr_vld",     32'(vld_m0),  32'h1);
        acc(1'b0, 8'h10, 24'h0, 3'b000);
        chk("reclear_10", 32'(dout_m0), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
